// File: rtl/multicycle_controller_if.sv
// Control/status bundle between multicycle_controller (master) and the multicycle datapath (slave).
interface multicycle_controller_if;
    logic [31:0] INSTRUCTION;
    logic [3:0]  FLAGS;
    logic        A3Src;
    logic        AdrSrc;
    logic        FlagUpdate;
    logic        IRWrite;
    logic        MemWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic        WD3Src;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  RegSrc;
    logic [2:0]  ALUop;
    logic [2:0]  ShiftType;

    modport master (
        input  INSTRUCTION, FLAGS,
        output A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
        output ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType
    );

    modport slave (
        output INSTRUCTION, FLAGS,
        input  A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
        input  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM-subset datapath (DP reg/imm, LDR/STR, B/BL, conditions).
// Define CTRL_SHIFT_EN to drive ShiftType from the register-operand shift field in EXECUTER.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_controller_if.master bus,
    output logic [STATE_W-1:0]     state_out,
    output logic                   undef
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic       immBit;
    logic [3:0] cmd;
    logic       sBit;
    logic       uBit;
    logic       lBit;
    logic       linkBit;
    logic       nFlag, zFlag, cFlag, vFlag;
    logic       condPass;
    logic       isCmp;
    logic [2:0] aluOpDp;
    logic [2:0] shiftDp;

    assign cond    = bus.INSTRUCTION[31:28];
    assign op      = bus.INSTRUCTION[27:26];
    assign immBit  = bus.INSTRUCTION[25];
    assign cmd     = bus.INSTRUCTION[24:21];
    assign sBit    = bus.INSTRUCTION[20];
    assign uBit    = bus.INSTRUCTION[23];
    assign lBit    = bus.INSTRUCTION[20];
    assign linkBit = bus.INSTRUCTION[24];
    assign {nFlag, zFlag, cFlag, vFlag} = bus.FLAGS;
    assign isCmp   = (cmd == 4'b1010);

`ifdef CTRL_SHIFT_EN
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.INSTRUCTION[19:12], bus.INSTRUCTION[4:0]};
    assign shiftDp = (bus.INSTRUCTION[11:7] != 5'd0) ? {1'b0, bus.INSTRUCTION[6:5]} : 3'b111;
`else
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.INSTRUCTION[19:0];
    assign shiftDp = 3'b111;
`endif

    always_comb begin
        case (cond)
            4'b0000: condPass = zFlag;
            4'b0001: condPass = ~zFlag;
            4'b0010: condPass = cFlag;
            4'b0011: condPass = ~cFlag;
            4'b0100: condPass = nFlag;
            4'b0101: condPass = ~nFlag;
            4'b0110: condPass = vFlag;
            4'b0111: condPass = ~vFlag;
            4'b1000: condPass = cFlag & ~zFlag;
            4'b1001: condPass = ~cFlag | zFlag;
            4'b1010: condPass = (nFlag == vFlag);
            4'b1011: condPass = (nFlag != vFlag);
            4'b1100: condPass = ~zFlag & (nFlag == vFlag);
            4'b1101: condPass = zFlag | (nFlag != vFlag);
            4'b1110: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    end

    // Commands without a dedicated ALU operation fall back to ADD.
    always_comb begin
        case (cmd)
            4'b0100:          aluOpDp = 3'b000;
            4'b0010, 4'b1010: aluOpDp = 3'b001;
            4'b0000:          aluOpDp = 3'b010;
            4'b1100:          aluOpDp = 3'b011;
            4'b0001:          aluOpDp = 3'b110;
            4'b1101:          aluOpDp = 3'b100;
            default:          aluOpDp = 3'b000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // All controls stay at their idle values while reset is low, so a reset mid-instruction
    // cannot leak a register or memory write.
    always_comb begin
        state_d        = FETCH;
        bus.A3Src      = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.FlagUpdate = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.WD3Src     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.RegSrc     = 2'b00;
        bus.ALUop      = 3'b000;
        bus.ShiftType  = 3'b111;
        undef          = 1'b0;
        if (reset) begin
            bus.RegSrc = {op == 2'b01, op == 2'b10};
            case (state_q)
                FETCH: begin
                    bus.IRWrite   = 1'b1;
                    bus.PCWrite   = 1'b1;
                    bus.ALUSrcB   = 2'b11;
                    bus.ResultSrc = 2'b10;
                    bus.RegSrc    = 2'b10;
                    state_d       = DECODE;
                end
                DECODE: begin
                    bus.ResultSrc = 2'b10;
                    if (op == 2'b11) begin
                        undef   = 1'b1;
                        state_d = FETCH;
                    end else if (!condPass) begin
                        state_d = FETCH;
                    end else if (op == 2'b01) begin
                        state_d = MEMADR;
                    end else if (op == 2'b00) begin
                        state_d = immBit ? EXECUTEI : EXECUTER;
                    end else begin
                        state_d = BRANCH;
                    end
                end
                MEMADR: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUop   = uBit ? 3'b000 : 3'b001;
                    state_d     = lBit ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    bus.AdrSrc  = 1'b1;
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b01;
                    state_d     = MEMWB;
                end
                MEMWB: begin
                    bus.AdrSrc    = 1'b1;
                    bus.RegWrite  = 1'b1;
                    bus.ResultSrc = 2'b01;
                    state_d       = FETCH;
                end
                MEMWRITE: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                    state_d      = FETCH;
                end
                EXECUTER, EXECUTEI: begin
                    bus.ALUSrcA    = 2'b01;
                    bus.ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
                    bus.ALUop      = aluOpDp;
                    bus.FlagUpdate = sBit | isCmp;
                    bus.ShiftType  = (state_q == EXECUTER) ? shiftDp : 3'b111;
                    state_d        = isCmp ? FETCH : ALUWB;
                end
                ALUWB: begin
                    bus.ALUSrcA  = 2'b01;
                    bus.RegWrite = 1'b1;
                    state_d      = FETCH;
                end
                BRANCH: begin
                    bus.ALUSrcA   = 2'b10;
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.PCWrite   = 1'b1;
                    bus.A3Src     = linkBit;
                    bus.WD3Src    = linkBit;
                    bus.RegWrite  = linkBit;
                    state_d       = FETCH;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign state_out = state_q;

endmodule
